// File: rtl/ga_sync_irq_if.sv
// Bus between the CRTC/CPU side and the gate-array sync/interrupt block.
// The master drives sync inputs and CPU strobes. The slave returns INT, MODE and monitor syncs.
interface ga_sync_irq_if;
   logic       CLKEN;
   logic       HSYNC_IN;
   logic       VSYNC_IN;
   logic       INT_ACK;
   logic       INT_CLR;
   logic [1:0] MODE_IN;
   logic       INT;
   logic [1:0] MODE;
   logic       HS_OUT;
   logic       VS_OUT;
   logic       CSYNC;
   logic [5:0] LINE_CNT;

   modport master (
      output CLKEN, HSYNC_IN, VSYNC_IN, INT_ACK, INT_CLR, MODE_IN,
      input  INT, MODE, HS_OUT, VS_OUT, CSYNC, LINE_CNT
   );

   modport slave (
      input  CLKEN, HSYNC_IN, VSYNC_IN, INT_ACK, INT_CLR, MODE_IN,
      output INT, MODE, HS_OUT, VS_OUT, CSYNC, LINE_CNT
   );
endinterface

// File: rtl/ga_sync_irq.sv
// Gate-array CRTC sync consumer: monitor HS/VS/CSYNC generation, screen-mode latch at HSYNC,
// and the 52-line CPU interrupt counter with VSYNC resync.
module ga_sync_irq #(
   parameter int unsigned HS_DELAY  = 2,
   parameter int unsigned HS_WIDTH  = 4,
   parameter int unsigned VS_DELAY  = 2,
   parameter int unsigned VS_WIDTH  = 4,
   parameter int unsigned INT_LINES = 52
) (
   input logic          CLOCK,
   input logic          nRESET,
   ga_sync_irq_if.slave bus
);
   localparam int unsigned HS_END     = HS_DELAY + HS_WIDTH;
   localparam int unsigned VS_END     = VS_DELAY + VS_WIDTH;
   localparam int unsigned RESYNC_MIN = 32;

   logic       hs_q, vs_q;
   logic [3:0] hs_cnt;
   logic [2:0] vs_hcnt;
   logic       vs_active;
   logic       hs_out_q, vs_out_q, int_q;
   logic [1:0] mode_q;
   logic [5:0] line_cnt_q;

   logic       hs_fall, vs_rise;
   logic [2:0] vs_base, vs_inc;
   logic       vs_count, resync, raise, int_nxt;
   logic [5:0] line_inc, line_nxt;

   assign hs_fall = bus.CLKEN & hs_q & ~bus.HSYNC_IN;
   assign vs_rise = bus.CLKEN & ~vs_q & bus.VSYNC_IN;

   // A fresh VSYNC restarts the edge count, so a coincident HSYNC edge counts as its first
   always_comb begin
      vs_base  = vs_rise ? 3'd0 : vs_hcnt;
      vs_inc   = vs_base + 3'd1;
      vs_count = hs_fall & bus.VSYNC_IN & (vs_rise | vs_active);
      resync   = vs_count & (vs_inc == 3'(VS_DELAY));
   end

   // Line counter and INT: clear beats everything, an INT raise beats a same-cycle acknowledge
   always_comb begin
      line_inc = line_cnt_q + 6'd1;
      line_nxt = line_cnt_q;
      int_nxt  = int_q;
      raise    = 1'b0;
      if (resync) begin
         line_nxt = 6'd0;
         raise    = (line_cnt_q >= 6'(RESYNC_MIN));
      end else if (hs_fall) begin
         if (line_inc == 6'(INT_LINES)) begin
            line_nxt = 6'd0;
            raise    = 1'b1;
         end else begin
            line_nxt = line_inc;
         end
      end
      if (raise)
         int_nxt = 1'b1;
      if (bus.INT_ACK) begin
         if (!raise)
            int_nxt = 1'b0;
         line_nxt = line_nxt & 6'h1F;
      end
      if (bus.INT_CLR) begin
         line_nxt = 6'd0;
         int_nxt  = 1'b0;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (!nRESET) begin
         hs_q       <= 1'b0;
         vs_q       <= 1'b0;
         hs_cnt     <= 4'd0;
         vs_hcnt    <= 3'd0;
         vs_active  <= 1'b0;
         hs_out_q   <= 1'b0;
         vs_out_q   <= 1'b0;
         int_q      <= 1'b0;
         mode_q     <= 2'd0;
         line_cnt_q <= 6'd0;
      end else begin
         int_q      <= int_nxt;
         line_cnt_q <= line_nxt;
         if (bus.CLKEN) begin
            hs_q <= bus.HSYNC_IN;
            vs_q <= bus.VSYNC_IN;
            if (bus.HSYNC_IN) begin
               if (hs_cnt != 4'hF)
                  hs_cnt <= hs_cnt + 4'd1;
               hs_out_q <= (hs_cnt >= 4'(HS_DELAY)) && (hs_cnt < 4'(HS_END));
               if (hs_cnt == 4'(HS_DELAY))
                  mode_q <= bus.MODE_IN;
            end else begin
               hs_cnt   <= 4'd0;
               hs_out_q <= 1'b0;
            end
            if (!bus.VSYNC_IN) begin
               vs_active <= 1'b0;
               vs_out_q  <= 1'b0;
            end else if (vs_count) begin
               vs_hcnt   <= vs_inc;
               vs_active <= 1'b1;
               if (vs_inc == 3'(VS_DELAY))
                  vs_out_q <= 1'b1;
               if (vs_inc == 3'(VS_END)) begin
                  vs_out_q  <= 1'b0;
                  vs_active <= 1'b0;
               end
            end else if (vs_rise) begin
               vs_hcnt   <= 3'd0;
               vs_active <= 1'b1;
            end
         end
      end
   end

   assign bus.INT      = int_q;
   assign bus.MODE     = mode_q;
   assign bus.HS_OUT   = hs_out_q;
   assign bus.VS_OUT   = vs_out_q;
   assign bus.CSYNC    = hs_out_q ^ vs_out_q;
   assign bus.LINE_CNT = line_cnt_q;
endmodule

// File: tb/tb_ga_sync_irq.sv
// Directed bench for ga_sync_irq: table-driven HSYNC/MODE vectors plus interrupt/VSYNC sequences.
module tb_ga_sync_irq;
   logic CLOCK = 1'b0;
   logic nRESET;
   ga_sync_irq_if sif ();

   ga_sync_irq dut (.CLOCK(CLOCK), .nRESET(nRESET), .bus(sif));

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      logic       hs;
      logic [1:0] mode_in;
      logic       exp_hs;
      logic [1:0] exp_mode;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic vec_t mk(logic hs, logic [1:0] mi, logic eh, logic [1:0] em);
      vec_t v;
      v.hs = hs; v.mode_in = mi; v.exp_hs = eh; v.exp_mode = em;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input logic h, input logic v, input logic ack, input logic clr);
      sif.HSYNC_IN = h; sif.VSYNC_IN = v; sif.INT_ACK = ack; sif.INT_CLR = clr; sif.CLKEN = 1'b1;
      @(posedge CLOCK); #1;
      sif.CLKEN = 1'b0; sif.INT_ACK = 1'b0; sif.INT_CLR = 1'b0;
      @(posedge CLOCK); #1;
   endtask

   // One short scan line; the HSYNC falling edge lands on the third tick
   task automatic line(input logic v, input logic ack, input logic clr);
      tick(1'b1, v, 1'b0, 1'b0);
      tick(1'b1, v, 1'b0, 1'b0);
      tick(1'b0, v, ack, clr);
      tick(1'b0, v, 1'b0, 1'b0);
   endtask

   task automatic lines(input int n, input logic v);
      for (int i = 0; i < n; i++) line(v, 1'b0, 1'b0);
   endtask

   task automatic pulse_ack();
      sif.INT_ACK = 1'b1;
      @(posedge CLOCK); #1;
      sif.INT_ACK = 1'b0;
   endtask

   task automatic do_reset();
      nRESET = 1'b0; sif.CLKEN = 1'b1; sif.HSYNC_IN = 1'b0; sif.VSYNC_IN = 1'b0;
      repeat (2) @(posedge CLOCK);
      #1; nRESET = 1'b1; sif.CLKEN = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " INT"},      8'(sif.INT), 8'd0);
      chk({tag, " LINE_CNT"}, 8'(sif.LINE_CNT), 8'd0);
      chk({tag, " MODE"},     8'(sif.MODE), 8'd0);
      chk({tag, " HS_OUT"},   8'(sif.HS_OUT), 8'd0);
      chk({tag, " VS_OUT"},   8'(sif.VS_OUT), 8'd0);
   endtask

   initial begin
      sif.CLKEN = 1'b0; sif.HSYNC_IN = 1'b0; sif.VSYNC_IN = 1'b0;
      sif.INT_ACK = 1'b0; sif.INT_CLR = 1'b0; sif.MODE_IN = 2'd0;

      // 14-tick HSYNC, MODE_IN=2: HS_OUT on ticks 3..6, MODE follows at tick 3
      tbl.push_back(mk(1, 2, 0, 0)); tbl.push_back(mk(1, 2, 0, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 2, 1, 2));
      for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 2, 0, 2));
      tbl.push_back(mk(0, 2, 0, 2));
      // 3-tick HSYNC, MODE_IN=1: one tick of HS_OUT, truncated
      tbl.push_back(mk(1, 1, 0, 2)); tbl.push_back(mk(1, 1, 0, 2));
      tbl.push_back(mk(1, 1, 1, 1)); tbl.push_back(mk(0, 1, 0, 1));
      // 2-tick HSYNC, MODE_IN=3: no HS_OUT, MODE held
      tbl.push_back(mk(1, 3, 0, 1)); tbl.push_back(mk(1, 3, 0, 1));
      tbl.push_back(mk(0, 3, 0, 1)); tbl.push_back(mk(0, 3, 0, 1));

      do_reset();
      chk_reset("reset");

      foreach (tbl[i]) begin
         sif.MODE_IN = tbl[i].mode_in;
         tick(tbl[i].hs, 1'b0, 1'b0, 1'b0);
         chk($sformatf("vec%0d HS_OUT", i), 8'(sif.HS_OUT), 8'(tbl[i].exp_hs));
         chk($sformatf("vec%0d MODE", i),   8'(sif.MODE),   8'(tbl[i].exp_mode));
         chk($sformatf("vec%0d CSYNC", i),  8'(sif.CSYNC),  8'(tbl[i].exp_hs));
      end

      do_reset();
      chk_reset("reset2");

      // 52 lines raise INT; ack with CLKEN low clears it; next INT 52 lines later
      lines(51, 1'b0);
      chk("l51 INT", 8'(sif.INT), 8'd0);
      chk("l51 LINE_CNT", 8'(sif.LINE_CNT), 8'd51);
      lines(1, 1'b0);
      chk("l52 INT", 8'(sif.INT), 8'd1);
      chk("l52 LINE_CNT", 8'(sif.LINE_CNT), 8'd0);
      pulse_ack();
      chk("ack INT", 8'(sif.INT), 8'd0);
      lines(51, 1'b0);
      chk("2nd l51 INT", 8'(sif.INT), 8'd0);
      lines(1, 1'b0);
      chk("2nd l52 INT", 8'(sif.INT), 8'd1);

      // Pending INT with LINE_CNT=36: ack clears INT and bit 5
      lines(36, 1'b0);
      chk("l36 LINE_CNT", 8'(sif.LINE_CNT), 8'd36);
      pulse_ack();
      chk("ack36 INT", 8'(sif.INT), 8'd0);
      chk("ack36 LINE_CNT", 8'(sif.LINE_CNT), 8'd4);

      // Ack coincident with the 52nd edge: raise wins
      lines(47, 1'b0);
      chk("pre-ack LINE_CNT", 8'(sif.LINE_CNT), 8'd51);
      line(1'b0, 1'b1, 1'b0);
      chk("ack+edge INT", 8'(sif.INT), 8'd1);
      chk("ack+edge LINE_CNT", 8'(sif.LINE_CNT), 8'd0);

      // Clear coincident with the 52nd edge: clear wins
      lines(51, 1'b0);
      line(1'b0, 1'b0, 1'b1);
      chk("clr+edge INT", 8'(sif.INT), 8'd0);
      chk("clr+edge LINE_CNT", 8'(sif.LINE_CNT), 8'd0);

      // VSYNC resync with LINE_CNT=40
      lines(40, 1'b0);
      chk("pre-vs40 LINE_CNT", 8'(sif.LINE_CNT), 8'd40);
      lines(1, 1'b1);
      chk("vs40 e1 LINE_CNT", 8'(sif.LINE_CNT), 8'd41);
      chk("vs40 e1 VS_OUT", 8'(sif.VS_OUT), 8'd0);
      lines(1, 1'b1);
      chk("vs40 e2 INT", 8'(sif.INT), 8'd1);
      chk("vs40 e2 LINE_CNT", 8'(sif.LINE_CNT), 8'd0);
      chk("vs40 e2 VS_OUT", 8'(sif.VS_OUT), 8'd1);
      chk("vs40 e2 CSYNC", 8'(sif.CSYNC), 8'd1);
      lines(3, 1'b1);
      chk("vs40 e5 VS_OUT", 8'(sif.VS_OUT), 8'd1);
      lines(1, 1'b1);
      chk("vs40 e6 VS_OUT", 8'(sif.VS_OUT), 8'd0);
      chk("vs40 e6 LINE_CNT", 8'(sif.LINE_CNT), 8'd4);
      lines(1, 1'b1);
      chk("vs40 e7 VS_OUT", 8'(sif.VS_OUT), 8'd0);
      chk("vs40 e7 LINE_CNT", 8'(sif.LINE_CNT), 8'd5);
      pulse_ack();
      chk("vs40 ack INT", 8'(sif.INT), 8'd0);

      // VSYNC resync with LINE_CNT=20: counter zeroed, no INT
      lines(15, 1'b0);
      chk("pre-vs20 LINE_CNT", 8'(sif.LINE_CNT), 8'd20);
      lines(2, 1'b1);
      chk("vs20 INT", 8'(sif.INT), 8'd0);
      chk("vs20 LINE_CNT", 8'(sif.LINE_CNT), 8'd0);
      chk("vs20 VS_OUT", 8'(sif.VS_OUT), 8'd1);
      lines(1, 1'b0);
      chk("vs20 end VS_OUT", 8'(sif.VS_OUT), 8'd0);
      chk("vs20 end LINE_CNT", 8'(sif.LINE_CNT), 8'd1);

      // One-line VSYNC: early end, no VS_OUT and no resync
      lines(39, 1'b0);
      lines(1, 1'b1);
      chk("vs1 e1 VS_OUT", 8'(sif.VS_OUT), 8'd0);
      chk("vs1 e1 LINE_CNT", 8'(sif.LINE_CNT), 8'd41);
      lines(2, 1'b0);
      chk("vs1 after VS_OUT", 8'(sif.VS_OUT), 8'd0);
      chk("vs1 after LINE_CNT", 8'(sif.LINE_CNT), 8'd43);
      chk("vs1 after INT", 8'(sif.INT), 8'd0);

      // Mid-frame reset with INT pending
      lines(12, 1'b0);
      chk("pre-rst INT", 8'(sif.INT), 8'd1);
      chk("pre-rst LINE_CNT", 8'(sif.LINE_CNT), 8'd3);
      do_reset();
      chk_reset("midreset");
      lines(1, 1'b0);
      chk("post-rst LINE_CNT", 8'(sif.LINE_CNT), 8'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
